rf_wb_arbiter: RTL

Write-port arbiter and scoreboard for the single-write-port integer register file of the RV32IM pipelined core. Merges the in-order writeback stream with results from the long-latency multiply/divide unit onto one registered write port. Tracks registers with pending long-latency writes and produces a decode-stage stall, plus a bubble request when the long-latency result is starved.

---
 rtl/rf_wb_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: merges in-order writeback with buffered
// long-latency results and tracks pending long-latency destinations for decode.
module rf_wb_arbiter #(
   parameter int STARVE_LIMIT    = 4,
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        wb_valid_i,
   input  logic [4:0]  wb_rd_i,
   input  logic [31:0] wb_data_i,
   input  logic        ll_valid_i,
   input  logic [4:0]  ll_rd_i,
   input  logic [31:0] ll_data_i,
   output logic        ll_ready_o,
   input  logic        ll_issue_i,
   input  logic [4:0]  ll_issue_rd_i,
   output logic        issue_ok_o,
   input  logic [4:0]  dec_rs1_i,
   input  logic [4:0]  dec_rs2_i,
   input  logic [4:0]  dec_rd_i,
   output logic        stall_o,
   output logic        bubble_req_o,
   output logic        rf_we_o,
   output logic [4:0]  rf_rd_o,
   output logic [31:0] rf_data_o
);

   logic        buf_valid_reg;
   logic [4:0]  buf_rd_reg;
   logic [31:0] buf_data_reg;
   logic [2:0]  out_cnt_reg;
   logic [3:0]  starve_reg;
   logic [3:0]  starve_next;
   logic        bubble_reg;
   logic        rf_we_reg;
   logic [4:0]  rf_rd_reg;
   logic [31:0] rf_data_reg;
   logic [31:0] busy_reg;

   logic wb_req, buf_win, ll_accept, ll_drop, issue_acc, op_done;

   assign wb_req    = wb_valid_i && (wb_rd_i != 5'd0);
   // The buffer never holds an x0 result, so any valid entry is writable.
   assign buf_win   = buf_valid_reg && !wb_req;
   assign ll_accept = ll_valid_i && !buf_valid_reg;
   assign ll_drop   = ll_accept && (ll_rd_i == 5'd0);
   assign issue_acc = ll_issue_i && issue_ok_o;
   assign op_done   = buf_win || ll_drop;

   assign ll_ready_o   = !buf_valid_reg;
   assign issue_ok_o   = out_cnt_reg < 3'(MAX_OUTSTANDING);
   assign stall_o      = busy_reg[dec_rs1_i] | busy_reg[dec_rs2_i] | busy_reg[dec_rd_i];
   assign bubble_req_o = bubble_reg;
   assign rf_we_o      = rf_we_reg;
   assign rf_rd_o      = rf_rd_reg;
   assign rf_data_o    = rf_data_reg;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         buf_valid_reg <= 1'b0;
         buf_rd_reg    <= 5'd0;
         buf_data_reg  <= 32'd0;
      end else if (buf_win) begin
         buf_valid_reg <= 1'b0;
      end else if (ll_accept && !ll_drop) begin
         buf_valid_reg <= 1'b1;
         buf_rd_reg    <= ll_rd_i;
         buf_data_reg  <= ll_data_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         out_cnt_reg <= 3'd0;
      end else if (issue_acc && !op_done) begin
         out_cnt_reg <= out_cnt_reg + 3'd1;
      end else if (!issue_acc && op_done) begin
         out_cnt_reg <= out_cnt_reg - 3'd1;
      end
   end

   assign busy_reg[0] = 1'b0;
   generate
      for (genvar gi = 1; gi < 32; gi++) begin : g_busy
         // A new issue to the same register outranks the retiring write.
         always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
               busy_reg[gi] <= 1'b0;
            end else if (issue_acc && (ll_issue_rd_i == 5'(gi))) begin
               busy_reg[gi] <= 1'b1;
            end else if (buf_win && (buf_rd_reg == 5'(gi))) begin
               busy_reg[gi] <= 1'b0;
            end
         end
      end
   endgenerate

   always_comb begin
      starve_next = starve_reg;
      if (!buf_valid_reg || buf_win) begin
         starve_next = 4'd0;
      end else if (starve_reg != 4'hF) begin
         starve_next = starve_reg + 4'd1;
      end
   end

   // Bubble is raised from the next count so it appears exactly
   // STARVE_LIMIT cycles after the buffer fills under constant wb traffic.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         starve_reg <= 4'd0;
         bubble_reg <= 1'b0;
      end else begin
         starve_reg <= starve_next;
         if (buf_win || !buf_valid_reg) begin
            bubble_reg <= 1'b0;
         end else if (starve_next >= 4'(STARVE_LIMIT)) begin
            bubble_reg <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rf_we_reg   <= 1'b0;
         rf_rd_reg   <= 5'd0;
         rf_data_reg <= 32'd0;
      end else begin
         rf_we_reg <= wb_req || buf_win;
         if (wb_req) begin
            rf_rd_reg   <= wb_rd_i;
            rf_data_reg <= wb_data_i;
         end else if (buf_win) begin
            rf_rd_reg   <= buf_rd_reg;
            rf_data_reg <= buf_data_reg;
         end
      end
   end

endmodule
